tier_counter_gen: RTL and testbench
===================================

Name: tier_counter_gen

Overview:
- Parametrised synchronous up/down counter tier with carry-in from the tier below and carry-out to the tier above, for cascading counter chains across die layers.
- Generalises the fixed carry-chain toggle counters with the following additions:
  - configurable width and modulus
  - direction control and parallel load
  - one-shot halt mode
  - optional registered carry for TSV timing
  - saturating wrap statistics

Parameters:
WIDTH, 16, counter width in bits (2..32)
MOD, 0, modulus; 0 = natural 2^WIDTH wrap, else counts 0..MOD-1 (2 <= MOD <= 2^WIDTH)
REG_CO, 1, 1 = co_OUT registered (one-cycle latency), 0 = combinational co_OUT
ONESHOT, 0, 1 = halt after first wrap until clr_IN or ld_IN

Ports:
clk1_IN  input  1  clock, rising edge
rst_n_IN  input  1  asynchronous active-low reset
clr_IN  input  1  synchronous clear
en_IN  input  1  local count enable
ci_IN  input  1  carry-in from lower tier; a count step requires en_IN & ci_IN
up_IN  input  1  1 = count up, 0 = count down
ld_IN  input  1  synchronous parallel load
ld_val_IN  input  WIDTH  load value
cnt_OUT  output  WIDTH  current count
tc_OUT  output  1  terminal count (combinational): up_IN ? cnt==MAXV : cnt==0
co_OUT  output  1  carry-out to upper tier
zero_OUT  output  1  cnt_OUT == 0 (combinational)
halt_OUT  output  1  FSM in HALT
wrap_cnt_OUT  output  8  saturating count of wrap events

Behaviour:
- MAXV = (MOD==0) ? 2^WIDTH-1 : MOD-1.
- Reset (async, rst_n_IN low):
  - cnt_OUT = 0, wrap_cnt_OUT = 0, co register = 0, FSM = RUN, halt_OUT = 0.
  - Deassertion is taken on the next clock edge; no count occurs on that edge unless stimulus is present.
- Per-edge priority: clr_IN > ld_IN > step > hold.
- clr_IN:
  - cnt = 0, wrap_cnt = 0, co register = 0, FSM -> RUN.
- ld_IN:
  - cnt = min(ld_val_IN, MAXV), i.e. out-of-range loads clamp to MAXV.
  - FSM -> RUN. wrap_cnt is unchanged. No carry is generated.
- step = en_IN & ci_IN & (FSM==RUN).
  - Up: cnt==MAXV ? 0 : cnt+1.
  - Down: cnt==0 ? MAXV : cnt-1.
- Wrap event = step & tc_OUT.
  - wrap_cnt increments, saturating at 255.
  - If ONESHOT=1, FSM -> HALT on the same edge, and cnt takes the wrapped value (0 when up, MAXV when down).
- FSM states:
  - RUN: steps allowed.
  - HALT: cnt holds and co is forced 0. Exit only via clr_IN or ld_IN. Reset also returns to RUN.
  - With ONESHOT=0, HALT is unreachable.
- co_OUT:
  - REG_CO=0: co_OUT = en_IN & ci_IN & tc_OUT & (FSM==RUN), same-cycle ripple.
  - REG_CO=1: co register <= wrap event, so co_OUT is high for exactly one cycle after the wrapping edge. The upper tier sees a one-cycle carry lag; this is accepted by design.
- A direction change mid-count takes effect on the next step. tc_OUT follows up_IN combinationally.
- If ld_IN and a step coincide, the load wins and no wrap is counted.
- If clr_IN and ld_IN coincide, clear wins.
- Reset asserted mid-count clears everything asynchronously, including a pending registered co.
- No X propagation from ld_val_IN when ld_IN=0.

Test Plan:
- Reset, then WIDTH=4, MOD=0, en=ci=up=1 for 17 cycles:
  - cnt runs 0..15 then 0, 1.
  - REG_CO=1: co_OUT high for exactly one cycle, the cycle after cnt 15->0.
  - wrap_cnt_OUT=1.
- MOD=10, down, ld_val=3, then 5 steps:
  - cnt 3,2,1,0,9,8.
  - tc_OUT high while cnt=0; wrap_cnt=1.
  - ld_val=12 loads 9 (clamp).
- ONESHOT=1, MOD=10, up from 8, en=ci=1:
  - cnt 9, then 0 with halt_OUT=1; stays 0 for 5 cycles, co_OUT 0 throughout those halted cycles.
  - ld_val=4 -> cnt 4, halt_OUT=0, counting resumes.
- ci_IN toggled 1,0,1,0 with en=1:
  - cnt advances only on ci=1 cycles.
  - REG_CO=0: co_OUT equals ci_IN & tc_OUT combinationally at cnt=MAXV.
- Simultaneous events:
  - clr+ld same edge -> cnt 0.
  - ld+step at cnt=MAXV -> cnt=ld value, wrap_cnt unchanged.
  - 300 wraps -> wrap_cnt_OUT=255.
- Drop rst_n_IN mid-cycle while registered co is pending:
  - All outputs 0 immediately (halt_OUT 0); no co pulse after release.

Source files
------------

// File: rtl/tier_counter_gen_if.sv
// ---------------------------------------------------------------------------
// tier_counter_gen_if
// Bundles the control inputs and status outputs of one counter tier so a
// chain of tiers (and the bench) can be wired with a single connection.
//
// Signals (direction as seen from the counter, i.e. the slave modport):
//   clr_IN        in   synchronous clear
//   en_IN         in   local count enable
//   ci_IN         in   carry-in from the tier below
//   up_IN         in   1 = count up, 0 = count down
//   ld_IN         in   synchronous parallel load
//   ld_val_IN     in   load value (WIDTH bits)
//   cnt_OUT       out  current count (WIDTH bits)
//   tc_OUT        out  terminal count for the current direction
//   co_OUT        out  carry-out to the tier above
//   zero_OUT      out  count is zero
//   halt_OUT      out  tier is halted after a one-shot wrap
//   wrap_cnt_OUT  out  saturating 8-bit wrap statistic
// ---------------------------------------------------------------------------
interface tier_counter_gen_if #(
    parameter int WIDTH = 16
);
    logic             clr_IN;
    logic             en_IN;
    logic             ci_IN;
    logic             up_IN;
    logic             ld_IN;
    logic [WIDTH-1:0] ld_val_IN;
    logic [WIDTH-1:0] cnt_OUT;
    logic             tc_OUT;
    logic             co_OUT;
    logic             zero_OUT;
    logic             halt_OUT;
    logic [7:0]       wrap_cnt_OUT;

    // Driver side: produces the controls, observes the status.
    modport master (
        output clr_IN, en_IN, ci_IN, up_IN, ld_IN, ld_val_IN,
        input  cnt_OUT, tc_OUT, co_OUT, zero_OUT, halt_OUT, wrap_cnt_OUT
    );

    // Counter side: consumes the controls, produces the status.
    modport slave (
        input  clr_IN, en_IN, ci_IN, up_IN, ld_IN, ld_val_IN,
        output cnt_OUT, tc_OUT, co_OUT, zero_OUT, halt_OUT, wrap_cnt_OUT
    );
endinterface

// File: rtl/tier_counter_gen.sv
// ---------------------------------------------------------------------------
// tier_counter_gen
// One tier of a cascadable up/down counter chain. A tier advances only when
// both its local enable and the carry-in from the tier below are high, and
// it signals the tier above with a carry-out on each wrap. Supports a
// modulus, parallel load with clamping, a one-shot halt after the first
// wrap, an optionally registered carry-out and a saturating wrap counter.
//
// The counter width is set by WIDTH. A zero modulus gives the natural
// binary wrap, while a non-zero modulus limits the count range. REG_CO
// chooses between a registered and a combinational carry-out, and ONESHOT
// makes the tier stop after its first wrap until it is cleared or loaded.
// Controls arrive and status leaves through the slave modport of
// tier_counter_gen_if; clock and active-low reset are separate ports.
// ---------------------------------------------------------------------------
module tier_counter_gen #(
    parameter int              WIDTH   = 16,
    parameter longint unsigned MOD     = 64'd0,
    parameter int              REG_CO  = 1,
    parameter int              ONESHOT = 0
) (
    input  logic               clk1_IN,
    input  logic               rst_n_IN,
    tier_counter_gen_if.slave  bus
);

    // Highest reachable count. MOD may equal 2^WIDTH, so the arithmetic is
    // done in 64 bits before being trimmed to the counter width.
    localparam longint unsigned MAXV_L = (MOD == 64'd0) ?
                                         ((64'd1 << WIDTH) - 64'd1) :
                                         (MOD - 64'd1);
    localparam logic [WIDTH-1:0] MAXV = MAXV_L[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [7:0]       wrapCnt_q, wrapCnt_d;
    logic             co_q,      co_d;
    logic [0:0]       state_q,   state_d;

    logic             running;
    logic             termCount;
    logic             stepEn;
    logic             wrapEvent;
    logic [WIDTH-1:0] ldClamp;

    // Terminal count follows the direction input directly, so a direction
    // change is visible on tc_OUT at once but only affects the next step.
    assign running   = (state_q == ST_RUN);
    assign termCount = bus.up_IN ? (cnt_q == MAXV) : (cnt_q == '0);
    assign stepEn    = bus.en_IN & bus.ci_IN & running;
    assign wrapEvent = stepEn & termCount;
    assign ldClamp   = (bus.ld_val_IN > MAXV) ? MAXV : bus.ld_val_IN;

    // Next-state selection with priority clear > load > step > hold.
    // The load value is only routed through when ld_IN is high, so an
    // undriven ld_val_IN cannot disturb the count while idle.
    always_comb begin
        cnt_d     = cnt_q;
        wrapCnt_d = wrapCnt_q;
        state_d   = state_q;
        co_d      = 1'b0;

        if (bus.clr_IN) begin
            cnt_d     = '0;
            wrapCnt_d = 8'd0;
            state_d   = ST_RUN;
        end else if (bus.ld_IN) begin
            cnt_d   = ldClamp;
            state_d = ST_RUN;
        end else if (stepEn) begin
            co_d = wrapEvent;
            if (bus.up_IN) begin
                cnt_d = termCount ? '0 : (cnt_q + ONE);
            end else begin
                cnt_d = termCount ? MAXV : (cnt_q - ONE);
            end
            if (wrapEvent) begin
                if (wrapCnt_q != 8'hFF) begin
                    wrapCnt_d = wrapCnt_q + 8'd1;
                end
                if (ONESHOT != 0) begin
                    state_d = ST_HALT;
                end
            end
        end
    end

    // State registers. Reset also drops any carry still waiting in co_q.
    always_ff @(posedge clk1_IN or negedge rst_n_IN) begin
        if (!rst_n_IN) begin
            cnt_q     <= '0;
            wrapCnt_q <= 8'd0;
            co_q      <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            cnt_q     <= cnt_d;
            wrapCnt_q <= wrapCnt_d;
            co_q      <= co_d;
            state_q   <= state_d;
        end
    end

    // The registered carry belongs to the wrapping edge itself, so it is
    // still delivered on the cycle a one-shot tier enters HALT; no new
    // carry can be produced while halted because stepping is blocked.
    assign bus.co_OUT       = (REG_CO != 0) ? co_q : wrapEvent;
    assign bus.cnt_OUT      = cnt_q;
    assign bus.tc_OUT       = termCount;
    assign bus.zero_OUT     = (cnt_q == '0);
    assign bus.halt_OUT     = (state_q == ST_HALT);
    assign bus.wrap_cnt_OUT = wrapCnt_q;

endmodule

// File: tb/tb_tier_counter_gen.sv
// ---------------------------------------------------------------------------
// tb_tier_counter_gen
// Drives three 4-bit counter tiers sharing one clock and reset:
//   A: MOD=0  (wrap at 16), registered carry, free running
//   B: MOD=10, combinational carry, free running
//   C: MOD=10, combinational carry, one-shot halt
// A reference model predicts every tier's outputs for each clock edge; the
// predictions are queued when stimulus is applied and compared by a monitor
// just after the edge. Each scenario task adds its own directed checks.
// ---------------------------------------------------------------------------
module tb_tier_counter_gen;

    typedef struct {
        int         d;
        logic [3:0] cnt;
        logic [7:0] wrap;
        logic       halt;
        logic       co;
        logic       zero;
        logic       tc;
    } exp_t;

    logic clk;
    logic rstN;

    logic       iClr[3];
    logic       iLd[3];
    logic       iEn[3];
    logic       iCi[3];
    logic       iUp[3];
    logic [3:0] iVal[3];

    logic [3:0] oCnt[3];
    logic       oTc[3];
    logic       oCo[3];
    logic       oZero[3];
    logic       oHalt[3];
    logic [7:0] oWrap[3];

    int cfgMod[3]     = '{0, 10, 10};
    int cfgRegCo[3]   = '{1, 0, 0};
    int cfgOneshot[3] = '{0, 0, 1};

    logic [3:0] mMax[3];
    logic [3:0] mCnt[3];
    logic [7:0] mWrap[3];
    logic       mHalt[3];
    logic       mCoQ[3];

    exp_t sb[$];
    exp_t mon;

    int testsRun    = 0;
    int testsFailed = 0;

    tier_counter_gen_if #(.WIDTH(4)) ifA();
    tier_counter_gen_if #(.WIDTH(4)) ifB();
    tier_counter_gen_if #(.WIDTH(4)) ifC();

    tier_counter_gen #(.WIDTH(4), .MOD(64'd0), .REG_CO(1), .ONESHOT(0)) dutA (
        .clk1_IN(clk), .rst_n_IN(rstN), .bus(ifA));
    tier_counter_gen #(.WIDTH(4), .MOD(64'd10), .REG_CO(0), .ONESHOT(0)) dutB (
        .clk1_IN(clk), .rst_n_IN(rstN), .bus(ifB));
    tier_counter_gen #(.WIDTH(4), .MOD(64'd10), .REG_CO(0), .ONESHOT(1)) dutC (
        .clk1_IN(clk), .rst_n_IN(rstN), .bus(ifC));

    // Map the per-tier stimulus arrays onto the three interfaces.
    assign ifA.clr_IN = iClr[0]; assign ifB.clr_IN = iClr[1]; assign ifC.clr_IN = iClr[2];
    assign ifA.ld_IN  = iLd[0];  assign ifB.ld_IN  = iLd[1];  assign ifC.ld_IN  = iLd[2];
    assign ifA.en_IN  = iEn[0];  assign ifB.en_IN  = iEn[1];  assign ifC.en_IN  = iEn[2];
    assign ifA.ci_IN  = iCi[0];  assign ifB.ci_IN  = iCi[1];  assign ifC.ci_IN  = iCi[2];
    assign ifA.up_IN  = iUp[0];  assign ifB.up_IN  = iUp[1];  assign ifC.up_IN  = iUp[2];
    assign ifA.ld_val_IN = iVal[0]; assign ifB.ld_val_IN = iVal[1]; assign ifC.ld_val_IN = iVal[2];

    // Map the three interfaces' status outputs back into arrays.
    assign oCnt[0] = ifA.cnt_OUT;  assign oCnt[1] = ifB.cnt_OUT;  assign oCnt[2] = ifC.cnt_OUT;
    assign oTc[0]  = ifA.tc_OUT;   assign oTc[1]  = ifB.tc_OUT;   assign oTc[2]  = ifC.tc_OUT;
    assign oCo[0]  = ifA.co_OUT;   assign oCo[1]  = ifB.co_OUT;   assign oCo[2]  = ifC.co_OUT;
    assign oZero[0] = ifA.zero_OUT; assign oZero[1] = ifB.zero_OUT; assign oZero[2] = ifC.zero_OUT;
    assign oHalt[0] = ifA.halt_OUT; assign oHalt[1] = ifB.halt_OUT; assign oHalt[2] = ifC.halt_OUT;
    assign oWrap[0] = ifA.wrap_cnt_OUT; assign oWrap[1] = ifB.wrap_cnt_OUT; assign oWrap[2] = ifC.wrap_cnt_OUT;

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: one ns after each rising edge, compare every
    // prediction queued for that edge against the tiers' outputs.
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0) begin
            mon = sb.pop_front();
            testsRun++;
            if (oCnt[mon.d] !== mon.cnt) begin
                testsFailed++;
                $display("[TB] FAIL sb_cnt dut%0d got %0d want %0d", mon.d, oCnt[mon.d], mon.cnt);
            end
            testsRun++;
            if (oWrap[mon.d] !== mon.wrap) begin
                testsFailed++;
                $display("[TB] FAIL sb_wrap dut%0d got %0d want %0d", mon.d, oWrap[mon.d], mon.wrap);
            end
            testsRun++;
            if (oHalt[mon.d] !== mon.halt) begin
                testsFailed++;
                $display("[TB] FAIL sb_halt dut%0d got %b want %b", mon.d, oHalt[mon.d], mon.halt);
            end
            testsRun++;
            if (oCo[mon.d] !== mon.co) begin
                testsFailed++;
                $display("[TB] FAIL sb_co dut%0d got %b want %b", mon.d, oCo[mon.d], mon.co);
            end
            testsRun++;
            if (oZero[mon.d] !== mon.zero) begin
                testsFailed++;
                $display("[TB] FAIL sb_zero dut%0d got %b want %b", mon.d, oZero[mon.d], mon.zero);
            end
            testsRun++;
            if (oTc[mon.d] !== mon.tc) begin
                testsFailed++;
                $display("[TB] FAIL sb_tc dut%0d got %b want %b", mon.d, oTc[mon.d], mon.tc);
            end
        end
    end

    // Reference model: advance tier k by one clock edge using its inputs.
    task automatic modelStep(input int k);
        logic tcNow, stepNow, wrapNow;
        tcNow   = iUp[k] ? (mCnt[k] == mMax[k]) : (mCnt[k] == 4'd0);
        stepNow = iEn[k] & iCi[k] & ~mHalt[k];
        wrapNow = stepNow & tcNow;
        if (iClr[k]) begin
            mCnt[k] = 4'd0; mWrap[k] = 8'd0; mCoQ[k] = 1'b0; mHalt[k] = 1'b0;
        end else if (iLd[k]) begin
            mCnt[k]  = (iVal[k] > mMax[k]) ? mMax[k] : iVal[k];
            mHalt[k] = 1'b0;
            mCoQ[k]  = 1'b0;
        end else begin
            mCoQ[k] = wrapNow;
            if (stepNow) begin
                if (iUp[k]) mCnt[k] = tcNow ? 4'd0 : mCnt[k] + 4'd1;
                else        mCnt[k] = tcNow ? mMax[k] : mCnt[k] - 4'd1;
            end
            if (wrapNow) begin
                if (mWrap[k] != 8'd255) mWrap[k] = mWrap[k] + 8'd1;
                if (cfgOneshot[k] != 0) mHalt[k] = 1'b1;
            end
        end
    endtask

    // Apply one cycle of stimulus to tier d (other tiers idle), queue the
    // predicted post-edge outputs of all tiers, then step past the edge.
    task automatic applyStimulus(input int d, input logic c, input logic l,
                                 input logic e, input logic ci, input logic u,
                                 input logic [3:0] v);
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            iClr[k] = 1'b0; iLd[k] = 1'b0; iEn[k] = 1'b0; iCi[k] = 1'b0;
        end
        iClr[d] = c; iLd[d] = l; iEn[d] = e; iCi[d] = ci; iUp[d] = u; iVal[d] = v;
        for (int k = 0; k < 3; k++) begin
            modelStep(k);
            x.d    = k;
            x.cnt  = mCnt[k];
            x.wrap = mWrap[k];
            x.halt = mHalt[k];
            x.zero = (mCnt[k] == 4'd0);
            x.tc   = iUp[k] ? (mCnt[k] == mMax[k]) : (mCnt[k] == 4'd0);
            x.co   = (cfgRegCo[k] != 0) ? mCoQ[k] : (iEn[k] & iCi[k] & x.tc & ~mHalt[k]);
            sb.push_back(x);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            testsRun++;
            if (oCnt[k] !== 4'd0 || oWrap[k] !== 8'd0 || oCo[k] !== 1'b0 ||
                oHalt[k] !== 1'b0 || oZero[k] !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL reset_state dut%0d got cnt=%0d wrap=%0d co=%b halt=%b zero=%b want 0 0 0 0 1",
                         k, oCnt[k], oWrap[k], oCo[k], oHalt[k], oZero[k]);
            end
        end
        #10 rstN = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        testsRun++;
        if (oCnt[0] !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release got %0d want 0", oCnt[0]);
        end
    endtask

    task automatic test_count_up();
        int   coHighs;
        logic wantCo;
        coHighs = 0;
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
            wantCo = (i == 16);
            testsRun++;
            if (oCnt[0] !== 4'(i % 16)) begin
                testsFailed++;
                $display("[TB] FAIL up_cnt step %0d got %0d want %0d", i, oCnt[0], i % 16);
            end
            testsRun++;
            if (oCo[0] !== wantCo) begin
                testsFailed++;
                $display("[TB] FAIL up_co step %0d got %b want %b", i, oCo[0], wantCo);
            end
            if (oCo[0] === 1'b1) coHighs++;
        end
        testsRun++;
        if (coHighs != 1) begin
            testsFailed++;
            $display("[TB] FAIL up_co_pulses got %0d want 1", coHighs);
        end
        testsRun++;
        if (oWrap[0] !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL up_wrap got %0d want 1", oWrap[0]);
        end
    endtask

    task automatic test_down_mod();
        logic [3:0] seq [5];
        seq = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        testsRun++;
        if (oCnt[1] !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL down_load got %0d want 3", oCnt[1]);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            testsRun++;
            if (oCnt[1] !== seq[i]) begin
                testsFailed++;
                $display("[TB] FAIL down_cnt step %0d got %0d want %0d", i, oCnt[1], seq[i]);
            end
            testsRun++;
            if (oTc[1] !== (seq[i] == 4'd0)) begin
                testsFailed++;
                $display("[TB] FAIL down_tc step %0d got %b want %b", i, oTc[1], seq[i] == 4'd0);
            end
        end
        testsRun++;
        if (oWrap[1] !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL down_wrap got %0d want 1", oWrap[1]);
        end
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12);
        testsRun++;
        if (oCnt[1] !== 4'd9) begin
            testsFailed++;
            $display("[TB] FAIL load_clamp got %0d want 9", oCnt[1]);
        end
    endtask

    task automatic test_oneshot();
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
        applyStimulus(2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        testsRun++;
        if (oCnt[2] !== 4'd9 || oHalt[2] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_nine got cnt=%0d halt=%b want 9 0", oCnt[2], oHalt[2]);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
            testsRun++;
            if (oCnt[2] !== 4'd0 || oHalt[2] !== 1'b1 || oCo[2] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL oneshot_halt cycle %0d got cnt=%0d halt=%b co=%b want 0 1 0",
                         i, oCnt[2], oHalt[2], oCo[2]);
            end
        end
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
        testsRun++;
        if (oCnt[2] !== 4'd4 || oHalt[2] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_reload got cnt=%0d halt=%b want 4 0", oCnt[2], oHalt[2]);
        end
        applyStimulus(2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        testsRun++;
        if (oCnt[2] !== 4'd5) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_resume got %0d want 5", oCnt[2]);
        end
    endtask

    task automatic test_carry_gate();
        logic       ciSeq [4];
        logic [3:0] cntSeq [4];
        ciSeq  = '{1'b1, 1'b0, 1'b1, 1'b0};
        cntSeq = '{4'd9, 4'd9, 4'd0, 4'd0};
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b0, 1'b0, 1'b1, ciSeq[i], 1'b1, 4'd0);
            testsRun++;
            if (oCnt[1] !== cntSeq[i]) begin
                testsFailed++;
                $display("[TB] FAIL ci_gate step %0d got %0d want %0d", i, oCnt[1], cntSeq[i]);
            end
            if (i == 0) begin
                iEn[1] = 1'b1; iCi[1] = 1'b1; iUp[1] = 1'b1;
                #1;
                testsRun++;
                if (oCo[1] !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL comb_co_ci1 got %b want 1", oCo[1]);
                end
                iCi[1] = 1'b0;
                #1;
                testsRun++;
                if (oCo[1] !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL comb_co_ci0 got %b want 0", oCo[1]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        testsRun++;
        if (oCnt[0] !== 4'd0 || oWrap[0] !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL clr_ld got cnt=%0d wrap=%0d want 0 0", oCnt[0], oWrap[0]);
        end
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        testsRun++;
        if (oCnt[0] !== 4'd5 || oWrap[0] !== 8'd0 || oCo[0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ld_step got cnt=%0d wrap=%0d co=%b want 5 0 0", oCnt[0], oWrap[0], oCo[0]);
        end
    endtask

    task automatic test_saturation();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 300 * 16; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        end
        testsRun++;
        if (oWrap[0] !== 8'd255 || oCnt[0] !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_saturate got wrap=%0d cnt=%0d want 255 0", oWrap[0], oCnt[0]);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        testsRun++;
        if (oCo[0] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL co_pending got %b want 1", oCo[0]);
        end
        #1 rstN = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            testsRun++;
            if (oCnt[k] !== 4'd0 || oWrap[k] !== 8'd0 || oCo[k] !== 1'b0 || oHalt[k] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL async_reset dut%0d got cnt=%0d wrap=%0d co=%b halt=%b want 0 0 0 0",
                         k, oCnt[k], oWrap[k], oCo[k], oHalt[k]);
            end
            mCnt[k] = 4'd0; mWrap[k] = 8'd0; mHalt[k] = 1'b0; mCoQ[k] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
            testsRun++;
            if (oCo[0] !== 1'b0 || oCnt[0] !== 4'd0) begin
                testsFailed++;
                $display("[TB] FAIL post_reset cycle %0d got co=%b cnt=%0d want 0 0", i, oCo[0], oCnt[0]);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        rstN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iClr[k] = 1'b0; iLd[k] = 1'b0; iEn[k] = 1'b0; iCi[k] = 1'b0;
            iUp[k] = 1'b1;  iVal[k] = 4'd0;
            mMax[k]  = (cfgMod[k] == 0) ? 4'd15 : 4'(cfgMod[k] - 1);
            mCnt[k]  = 4'd0; mWrap[k] = 8'd0; mHalt[k] = 1'b0; mCoQ[k] = 1'b0;
        end
        test_reset();
        test_count_up();
        test_down_mod();
        test_oneshot();
        test_carry_gate();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        #20;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
